regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port among up to four writeback requesters (e.g. ALU result, load data, link/JAL). Each requester owns a one-entry holding slot with a valid/ready handshake. The arbiter drains slots oldest-first into registered write-port outputs, discards writes to register 0, and publishes a per-register pending-write mask so decode can stall on read-after-write hazards.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- ReqValid  in  NUM_REQ  requester i presents a write
- ReqReady  out  NUM_REQ  slot i can accept
- ReqAddr  in  NUM_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- ReqData  in  NUM_REQ*DATA_W  write data, packed the same way
- WriteAddress  out  ADDR_W  register file write address
- WriteData  out  DATA_W  register file write data
- ReadWriteEn  out  1  register file write enable
- BusyMask  out  2**ADDR_W  bit r set while a write to register r is outstanding

## Operation
- **Slot state.** Per requester: empty or full, plus address and data. ReqReady[i] = slot i empty AND out-of-reset flag set. The flag is a flop cleared by reset and set on the first posedge after RST_N rises.
- **Accept.** A transfer occurs when ReqValid[i] & ReqReady[i] at a posedge; the slot captures ReqAddr and ReqData.
- **Register 0.** A request with address 0 is handshaken normally but never fills the slot and never produces a write.
- **Age.** An NUM_REQ×NUM_REQ age matrix records fill order. A newly filled slot becomes younger than every currently full slot.
- **Grant.** Each posedge, if any slot is full, grant the oldest full slot.
  - Slots filled on the same edge are ordered by a round-robin pointer: lowest index at or after the pointer is treated as oldest.
  - The pointer advances to (granted index + 1) mod NUM_REQ after each grant.
- **Write-port outputs.** On a grant edge, WriteAddress and WriteData load from the granted slot, ReadWriteEn goes to 1, and the slot empties. With no grant, ReadWriteEn goes to 0 and WriteAddress/WriteData hold.
- **Same-address ordering.** Two full slots with the same address always issue oldest first, so the last-accepted value wins.
- **BusyMask.** Bit r is the OR of (slot full AND slot address == r) over all slots, plus (ReadWriteEn AND WriteAddress == r). The output is combinational from state; bit 0 is always 0.

## Timing
- **Reset values.** Slots empty, age matrix clear, pointer 0, WriteAddress 0, WriteData 0, ReadWriteEn 0, BusyMask all 0, ReqReady all 0.
- **Latency.**
  - Request accepted at edge k.
  - Earliest grant at edge k+1; ReadWriteEn is high during cycle k+1.
  - The register file commits on the negedge inside cycle k+1.
  - The BusyMask bit clears at edge k+2 unless another write to the same register is pending.
- **Per-requester throughput.** ReqReady[i] is 0 while slot i is full. A requester granted at edge k+1 may send again from cycle k+1 onward, giving at most one accept per two cycles when uncontended. Total port throughput is one write per cycle.
- **Accept and grant on the same edge, same slot.** Impossible by construction: an accept requires the slot empty, a grant requires it full.
- **Reset mid-operation.** Asserting RST_N low clears all pending slot contents with no write issued, and forces ReadWriteEn to 0 immediately (asynchronous).

## Structure
- **Shared package** (rf_pkg): NUM_REGS = 32, ZERO_REG = 0, default ADDR_W and DATA_W, and the slot record type {full, addr, data}.
- **Sub-module** regfile_wb_slot: the one-entry holding buffer with ready generation and register-0 discard, instantiated NUM_REQ times.
- **Top level:** age matrix, grant logic, output registers and BusyMask.

## Test plan
- **Reset.** Hold RST_N=0 for 3 cycles while driving ReqValid → ReqReady=0 and ReadWriteEn=0 throughout; ReqReady=1 on the first cycle after release.
- **Single write.** Req0 {addr 8, data 0x0000_0005} accepted at edge k → WriteAddress=8, WriteData=5, ReadWriteEn=1 during cycle k+1; BusyMask[8]=1 in cycles k..k+1 and 0 at k+2.
- **Simultaneous fill.** Req0 {10, 0xA} and Req1 {11, 0xB} accepted on the same edge with pointer 0 → reg 10 written at k+1, reg 11 at k+2; pointer ends at 0.
- **Same-address ordering.** Req1 {10, 0x1} accepted at k, Req0 {10, 0x2} at k+1 → writes issue in order 0x1 then 0x2; register 10 ends at 0x2; BusyMask[10] stays set until the 0x2 write completes.
- **Register 0.** Req0 {0, 0xFFFF_FFFF} → handshake completes, ReadWriteEn stays 0, BusyMask[0]=0, ReqReady[0] remains 1.
- **Reset mid-operation.** Assert RST_N with both slots full → no write issued, ReadWriteEn=0 immediately, BusyMask clears immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Register-file geometry, the discarded destination register and the
// holding-slot record used by the arbiter and its models.
package rf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int ZERO_REG  = 0;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  // Upper bound on requesters; grant/pointer indices are sized for this.
  localparam int MAX_REQ   = 4;

  typedef struct packed {
    logic                 full;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/regfile_wb_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
// Ports: clk/rst_n; live_i (out-of-reset flag); vld_i/addr_i/data_i request;
// clr_i (slot granted, empty it); rdy_o, fill_o, full_o, addr_o, data_o.
module regfile_wb_slot
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  output logic              rdy_o,
  output logic              fill_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign rdy_o  = ~full_q & live_i;
  // Writes to the zero register complete the handshake but are dropped here.
  assign fill_o = vld_i & rdy_o & (addr_i != ADDR_W'(ZERO_REG));
  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

  // clr_i and fill_o are mutually exclusive: a grant needs full, a fill empty.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_i) full_d = 1'b0;
    if (fill_o) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback slots, oldest first.
// Ports: CLK/RST_N; ReqValid/ReqReady/ReqAddr/ReqData per requester (packed);
// WriteAddress/WriteData/ReadWriteEn registered write port; BusyMask pending writes.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        ReqValid,
  output logic [NUM_REQ-1:0]        ReqReady,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [ADDR_W-1:0]         WriteAddress,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      ReadWriteEn,
  output logic [2**ADDR_W-1:0]      BusyMask
);

  logic                    live_q;
  logic [NUM_REQ-1:0]      full, fill, clr;
  logic [ADDR_W-1:0]       s_addr [MAX_REQ];
  logic [DATA_W-1:0]       s_data [MAX_REQ];

  // older_q[i][j]: slot i was filled strictly before slot j.
  logic [NUM_REQ-1:0][NUM_REQ-1:0] older_q, older_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [MAX_REQ-1:0]      cand;
  logic [2:0]              idx3;
  logic                    gnt_vld;
  logic [1:0]              gnt_idx;

  logic [ADDR_W-1:0]       wa_q, wa_d;
  logic [DATA_W-1:0]       wd_q, wd_d;
  logic                    we_q, we_d;

  for (genvar g = 0; g < MAX_REQ; g++) begin : g_slot
    if (g < NUM_REQ) begin : g_on
      regfile_wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
        .clk    (CLK),
        .rst_n  (RST_N),
        .live_i (live_q),
        .vld_i  (ReqValid[g]),
        .addr_i (ReqAddr[g*ADDR_W +: ADDR_W]),
        .data_i (ReqData[g*DATA_W +: DATA_W]),
        .clr_i  (clr[g]),
        .rdy_o  (ReqReady[g]),
        .fill_o (fill[g]),
        .full_o (full[g]),
        .addr_o (s_addr[g]),
        .data_o (s_data[g])
      );
    end else begin : g_off
      assign s_addr[g] = '0;
      assign s_data[g] = '0;
    end
  end

  // A slot is a candidate when no full slot is older. Candidates are exactly
  // the slots filled on the oldest fill edge; the pointer breaks that tie.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = full[i];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (full[j] && older_q[j][i]) cand[i] = 1'b0;
      end
    end
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx3    = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      idx3 = {1'b0, ptr_q} + 3'(o);
      if (idx3 >= 3'(NUM_REQ)) idx3 = idx3 - 3'(NUM_REQ);
      if (!gnt_vld && cand[idx3[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx3[1:0];
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_REQ; i++) clr[i] = gnt_vld && (gnt_idx == 2'(i));
  end

  // A new fill is younger than every currently full slot; its own row is
  // cleared so stale bits from a previous occupancy never survive.
  always_comb begin
    older_d = older_q;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (fill[j]) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          older_d[i][j] = full[i];
          older_d[j][i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    wa_d  = wa_q;
    wd_d  = wd_q;
    we_d  = 1'b0;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == 2'(NUM_REQ-1)) ? 2'd0 : gnt_idx + 2'd1;
      wa_d  = s_addr[gnt_idx];
      wd_d  = s_data[gnt_idx];
      we_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live_q  <= 1'b0;
      older_q <= '0;
      ptr_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      older_q <= older_d;
      ptr_q   <= ptr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
    end
  end

  assign WriteAddress = wa_q;
  assign WriteData    = wd_q;
  assign ReadWriteEn  = we_q;

  // Pending = held in a slot, or on the write port this cycle.
  always_comb begin
    BusyMask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full[i]) BusyMask[s_addr[i]] = 1'b1;
    end
    if (we_q) BusyMask[wa_q] = 1'b1;
    BusyMask[ADDR_W'(ZERO_REG)] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int N  = 2;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int NR = 2**AW;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    ReqValid;
  logic [N-1:0]    ReqReady;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DW-1:0] ReqData;
  logic [AW-1:0]   WriteAddress;
  logic [DW-1:0]   WriteData;
  logic            ReadWriteEn;
  logic [NR-1:0]   BusyMask;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqAddr      (ReqAddr),
    .ReqData      (ReqData),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .ReadWriteEn  (ReadWriteEn),
    .BusyMask     (BusyMask)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: slots carry a fill timestamp; oldest stamp wins.
  slot_t         m_slot [N];
  int            m_stamp [N];
  int            m_ptr;
  bit            m_live;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  bit            m_we;
  int            m_cycle;
  logic [DW-1:0] m_rf [NR];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_slot[i]  = '0;
      m_stamp[i] = 0;
    end
    m_ptr  = 0;
    m_live = 0;
    m_wa   = '0;
    m_wd   = '0;
    m_we   = 0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_live && !m_slot[i].full;
    return r;
  endfunction

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (m_slot[i].full) m[m_slot[i].addr] = 1'b1;
    if (m_we) m[m_wa] = 1'b1;
    return m;
  endfunction

  task automatic model_edge();
    logic [N-1:0]  rdy;
    logic [AW-1:0] a;
    int best, idx;
    rdy  = model_ready();
    best = -1;
    for (int o = 0; o < N; o++) begin
      idx = (m_ptr + o) % N;
      if (m_slot[idx].full && (best < 0 || m_stamp[idx] < m_stamp[best])) best = idx;
    end
    if (best >= 0) begin
      m_wa = m_slot[best].addr;
      m_wd = m_slot[best].data;
      m_we = 1;
      m_slot[best].full = 1'b0;
      m_ptr = (best + 1) % N;
      m_rf[m_wa] = m_wd;
    end else begin
      m_we = 0;
    end
    for (int i = 0; i < N; i++) begin
      a = ReqAddr[i*AW +: AW];
      if (ReqValid[i] && rdy[i] && a != '0) begin
        m_slot[i].full = 1'b1;
        m_slot[i].addr = a;
        m_slot[i].data = ReqData[i*DW +: DW];
        m_stamp[i]     = m_cycle;
      end
    end
    m_live = 1;
    m_cycle++;
  endtask

  // Single compare process, every cycle on the falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ready",  64'(ReqReady),     64'(model_ready()));
      chk("waddr",  64'(WriteAddress), 64'(m_wa));
      chk("wdata",  64'(WriteData),    64'(m_wd));
      chk("wen",    64'(ReadWriteEn),  64'(m_we));
      chk("busy",   64'(BusyMask),     64'(model_busy()));
    end
  end

  task automatic step();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_edge();
    @(negedge CLK);
  endtask

  task automatic drive(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    ReqAddr[i*AW +: AW] = a;
    ReqData[i*DW +: DW] = d;
  endtask

  initial begin
    RST_N    = 1'b0;
    ReqValid = '0;
    ReqAddr  = '0;
    ReqData  = '0;
    m_cycle  = 0;
    for (int r = 0; r < NR; r++) m_rf[r] = '0;
    model_reset();
    @(negedge CLK);
    chk_en = 1;

    // Reset held with requests driven.
    ReqValid = '1;
    drive(0, 5'd3, 32'h1111);
    drive(1, 5'd4, 32'h2222);
    repeat (3) begin
      step();
      chk("rst_ready", 64'(ReqReady), 64'(0));
      chk("rst_wen",   64'(ReadWriteEn), 64'(0));
    end
    RST_N = 1'b1;
    step();
    chk("ready_after_rst", 64'(ReqReady), 64'(2'b11));
    chk("no_write_after_rst", 64'(ReadWriteEn), 64'(0));
    ReqValid = '0;

    // Simultaneous fill, pointer at 0.
    drive(0, 5'd10, 32'hA);
    drive(1, 5'd11, 32'hB);
    ReqValid = 2'b11;
    step();
    ReqValid = '0;
    chk("sim_busy", 64'(BusyMask), 64'(32'h0000_0C00));
    step();
    chk("sim_first_addr", 64'(WriteAddress), 64'(10));
    chk("sim_first_data", 64'(WriteData),    64'(32'hA));
    step();
    chk("sim_second_addr", 64'(WriteAddress), 64'(11));
    chk("sim_second_data", 64'(WriteData),    64'(32'hB));
    step();
    // Pointer should be back at 0: slot 0 wins the next tie.
    drive(0, 5'd12, 32'hC);
    drive(1, 5'd13, 32'hD);
    ReqValid = 2'b11;
    step();
    ReqValid = '0;
    step();
    chk("ptr_wrap_addr", 64'(WriteAddress), 64'(12));
    step();
    step();

    // Single write.
    drive(0, 5'd8, 32'h5);
    ReqValid = 2'b01;
    step();
    ReqValid = '0;
    chk("single_busy_k", 64'(BusyMask[8]), 64'(1));
    chk("single_wen_k",  64'(ReadWriteEn), 64'(0));
    step();
    chk("single_addr", 64'(WriteAddress), 64'(8));
    chk("single_data", 64'(WriteData),    64'(5));
    chk("single_wen",  64'(ReadWriteEn),  64'(1));
    chk("single_busy_k1", 64'(BusyMask[8]), 64'(1));
    step();
    chk("single_busy_k2", 64'(BusyMask[8]), 64'(0));

    // Same-address ordering.
    drive(1, 5'd10, 32'h1);
    ReqValid = 2'b10;
    step();
    drive(0, 5'd10, 32'h2);
    ReqValid = 2'b01;
    step();
    ReqValid = '0;
    chk("same_first",   64'(WriteData), 64'(1));
    chk("same_busy_k1", 64'(BusyMask[10]), 64'(1));
    step();
    chk("same_second",  64'(WriteData), 64'(2));
    chk("same_busy_k2", 64'(BusyMask[10]), 64'(1));
    step();
    chk("same_busy_k3", 64'(BusyMask[10]), 64'(0));
    chk("same_rf10",    64'(m_rf[10]), 64'(2));

    // Register 0 write is dropped.
    drive(0, 5'd0, 32'hFFFF_FFFF);
    ReqValid = 2'b01;
    chk("r0_ready_pre", 64'(ReqReady[0]), 64'(1));
    step();
    ReqValid = '0;
    chk("r0_wen",   64'(ReadWriteEn), 64'(0));
    chk("r0_busy0", 64'(BusyMask[0]), 64'(0));
    chk("r0_ready", 64'(ReqReady[0]), 64'(1));
    step();
    chk("r0_wen2",  64'(ReadWriteEn), 64'(0));

    // Randomized traffic.
    repeat (400) begin
      ReqValid = N'($urandom);
      for (int i = 0; i < N; i++) drive(i, AW'($urandom_range(0, 7)), $urandom);
      step();
    end
    ReqValid = '0;
    repeat (4) step();

    // Reset mid-operation.
    drive(0, 5'd3, 32'h33);
    drive(1, 5'd4, 32'h44);
    ReqValid = 2'b11;
    step();
    ReqValid = '0;
    step();
    chk("mid_wen_before", 64'(ReadWriteEn), 64'(1));
    #1 RST_N = 1'b0;
    #1;
    chk("mid_wen_async",  64'(ReadWriteEn), 64'(0));
    chk("mid_busy_async", 64'(BusyMask),    64'(0));
    chk("mid_ready",      64'(ReqReady),    64'(0));
    model_reset();
    step();
    step();
    RST_N = 1'b1;
    step();
    chk("mid_ready_after", 64'(ReqReady), 64'(2'b11));
    step();
    chk("mid_no_write", 64'(ReadWriteEn), 64'(0));

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
